// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words, buffers them through an
// encode stage and a FIFO, and streams them sequentially into instruction memory.
module instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        opcode,
    input  logic [3:0]        rdst,
    input  logic [3:0]        rsrc,
    input  logic [7:0]        immediate,
    input  logic [3:0]        flag_type,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              enc_err,
    output logic [ADDR_W:0]   word_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       fifo_q [DEPTH];
    logic [15:0]       fifo_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              s1_valid_q, s1_valid_d;
    logic [15:0]       s1_word_q, s1_word_d;
    logic              enc_err_q, enc_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wc_q, wc_d;

    logic        enc_legal, accept, full, push, pop;
    logic [15:0] enc_word;

    always_comb begin
        enc_legal = 1'b0;
        enc_word  = {opcode, rdst, rsrc};
        unique case (flag_type)
            4'b0010: begin
                enc_legal = (opcode == 8'h05);
                enc_word  = {4'b0101, rdst, immediate};
            end
            4'b0001: begin
                case (opcode)
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                    8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: enc_legal = 1'b1;
                    default: enc_legal = 1'b0;
                endcase
            end
            4'b0100: enc_legal = (opcode == 8'h85);
            4'b0101: enc_legal = (opcode == 8'h87);
            4'b0000: begin
                enc_legal = (opcode == 8'h00);
                enc_word  = 16'h0000;
            end
            default: enc_legal = 1'b0;
        endcase
    end

    // S1 counts as one extra slot: a word may sit in S1 while the FIFO is full,
    // so the block absorbs DEPTH+1 words before stalling.
    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !reset && !prog_start && !(full && s1_valid_q);
    assign accept    = in_valid && in_ready;
    assign mem_we    = (state_q == WRITE) && !reset && !prog_start;
    assign pop       = mem_we && mem_ready;
    assign push      = s1_valid_q && (!full || pop);
    assign mem_addr  = addr_q;
    assign mem_wdata = (state_q == WRITE) ? fifo_q[rd_ptr_q] : 16'h0000;
    assign enc_err   = enc_err_q;
    assign word_count = wc_q;

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        addr_d     = addr_q;
        wc_d       = wc_q;
        enc_err_d  = accept && !enc_legal;

        if (push) begin
            fifo_d[wr_ptr_q] = s1_word_q;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + 1'b1;
            if (wc_q != '1) wc_d = wc_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (accept) begin
            s1_valid_d = enc_legal;
            s1_word_d  = enc_word;
        end else if (push) begin
            s1_valid_d = 1'b0;
        end

        // Going to WRITE on the push edge gives the 2-cycle accept-to-write latency.
        state_d = (count_d != '0) ? WRITE : IDLE;

        if (prog_start) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            s1_valid_d = 1'b0;
            addr_d     = BASE;
            wc_d       = '0;
            enc_err_d  = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            enc_err_q  <= 1'b0;
            addr_q     <= BASE;
            wc_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            enc_err_q  <= enc_err_d;
            addr_q     <= addr_d;
            wc_q       <= wc_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4, ADDR_W=4, BASE_ADDR=E).
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  opcode = '0;
    logic [3:0]  rdst = '0;
    logic [3:0]  rsrc = '0;
    logic [7:0]  immediate = '0;
    logic [3:0]  flag_type = '0;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        enc_err;
    logic [4:0]  word_count;

    int pass_cnt = 0;
    int check_cnt = 0;
    int we_seen = 0;
    logic [3:0]  log_addr[$];
    logic [15:0] log_data[$];

    instr_encoder_loader #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(14)) dut (
        .clk(clk), .reset(reset), .prog_start(prog_start),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rdst(rdst), .rsrc(rsrc), .immediate(immediate), .flag_type(flag_type),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .enc_err(enc_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) we_seen++;
        if (mem_we && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [7:0] imm, input logic [3:0] fl);
        bit ok = 0;
        in_valid = 1'b1; opcode = op; rdst = rd; rsrc = rs; immediate = imm; flag_type = fl;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_cnt++;
        if (!ok) $display("FAIL send_accept: op %h not accepted within 20 cycles", op);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(2);
        @(negedge clk);
        check_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        check_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else pass_cnt++;
        check_cnt++; if (mem_addr !== 4'hE) $display("FAIL rst_mem_addr: got %h want e", mem_addr); else pass_cnt++;
        check_cnt++; if (mem_wdata !== 16'h0000) $display("FAIL rst_mem_wdata: got %h want 0000", mem_wdata); else pass_cnt++;
        check_cnt++; if (enc_err !== 1'b0) $display("FAIL rst_enc_err: got %b want 0", enc_err); else pass_cnt++;
        check_cnt++; if (word_count !== 5'd0) $display("FAIL rst_word_count: got %0d want 0", word_count); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        int base = log_addr.size();
        send(8'h05, 4'd3, 4'd5, 8'h00, 4'b0001);
        @(negedge clk);
        check_cnt++; if (mem_we !== 1'b0) $display("FAIL rtype_early_we: got %b want 0", mem_we); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        check_cnt++; if (mem_we !== 1'b1) $display("FAIL rtype_we: got %b want 1", mem_we); else pass_cnt++;
        check_cnt++; if (mem_addr !== 4'hE) $display("FAIL rtype_addr: got %h want e", mem_addr); else pass_cnt++;
        check_cnt++; if (mem_wdata !== 16'h0535) $display("FAIL rtype_data: got %h want 0535", mem_wdata); else pass_cnt++;
        cycles(3);
        check_cnt++; if (log_addr.size() !== base + 1) $display("FAIL rtype_nwrites: got %0d want %0d", log_addr.size() - base, 1); else pass_cnt++;
        check_cnt++; if (word_count !== 5'd1) $display("FAIL rtype_wc: got %0d want 1", word_count); else pass_cnt++;
    endtask

    task automatic test_types_wrap();
        int base = log_addr.size();
        logic [3:0]  ea[3];
        logic [15:0] ed[3];
        ea[0] = 4'hF; ea[1] = 4'h0; ea[2] = 4'h1;
        ed[0] = 16'h527F; ed[1] = 16'h8412; ed[2] = 16'h8746;
        send(8'h05, 4'd2, 4'd0, 8'h7F, 4'b0010);
        send(8'h84, 4'd1, 4'd2, 8'h00, 4'b0001);
        send(8'h87, 4'd4, 4'd6, 8'h00, 4'b0101);
        cycles(6);
        check_cnt++;
        if (log_addr.size() !== base + 3) $display("FAIL types_nwrites: got %0d want 3", log_addr.size() - base);
        else begin
            pass_cnt++;
            for (int i = 0; i < 3; i++) begin
                check_cnt++;
                if (log_addr[base+i] !== ea[i] || log_data[base+i] !== ed[i])
                    $display("FAIL types_word%0d: got %h@%h want %h@%h", i, log_data[base+i], log_addr[base+i], ed[i], ea[i]);
                else pass_cnt++;
            end
        end
        check_cnt++; if (word_count !== 5'd4) $display("FAIL wrap_wc: got %0d want 4", word_count); else pass_cnt++;
    endtask

    task automatic test_illegal();
        int base = log_addr.size();
        int wb;
        send(8'h0A, 4'd1, 4'd2, 8'h00, 4'b0001);
        @(negedge clk);
        check_cnt++; if (enc_err !== 1'b1) $display("FAIL illegal_err: got %b want 1", enc_err); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        check_cnt++; if (enc_err !== 1'b0) $display("FAIL illegal_err_pulse: got %b want 0", enc_err); else pass_cnt++;
        send(8'h06, 4'd1, 4'd2, 8'h11, 4'b0010);
        @(negedge clk);
        check_cnt++; if (enc_err !== 1'b1) $display("FAIL illegal_itype_err: got %b want 1", enc_err); else pass_cnt++;
        cycles(4);
        check_cnt++; if (log_addr.size() !== base) $display("FAIL illegal_nowrite: got %0d writes want 0", log_addr.size() - base); else pass_cnt++;
        check_cnt++; if (word_count !== 5'd4) $display("FAIL illegal_wc: got %0d want 4", word_count); else pass_cnt++;
        wb = log_addr.size();
        send(8'h01, 4'd1, 4'd1, 8'h00, 4'b0001);
        send(8'h00, 4'd0, 4'd0, 8'h00, 4'b0000);
        send(8'h85, 4'd7, 4'd8, 8'h00, 4'b0100);
        cycles(6);
        check_cnt++;
        if (log_addr.size() !== wb + 3) $display("FAIL illegal_next_n: got %0d want 3", log_addr.size() - wb);
        else begin
            pass_cnt++;
            check_cnt++; if (log_addr[wb] !== 4'h2 || log_data[wb] !== 16'h0111) $display("FAIL illegal_next_word: got %h@%h want 0111@2", log_data[wb], log_addr[wb]); else pass_cnt++;
            check_cnt++; if (log_addr[wb+1] !== 4'h3 || log_data[wb+1] !== 16'h0000) $display("FAIL wait_word: got %h@%h want 0000@3", log_data[wb+1], log_addr[wb+1]); else pass_cnt++;
            check_cnt++; if (log_addr[wb+2] !== 4'h4 || log_data[wb+2] !== 16'h8578) $display("FAIL load_word: got %h@%h want 8578@4", log_data[wb+2], log_addr[wb+2]); else pass_cnt++;
        end
        check_cnt++; if (word_count !== 5'd7) $display("FAIL illegal_wc2: got %0d want 7", word_count); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0]  ops[8];
        logic [15:0] ed[8];
        int base = log_addr.size();
        int idx = 0;
        int first_stall = -1;
        ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h03; ops[3] = 8'h04;
        ops[4] = 8'h06; ops[5] = 8'h07; ops[6] = 8'h08; ops[7] = 8'h09;
        for (int i = 0; i < 8; i++) ed[i] = {ops[i], 4'(i), 4'(15 - i)};
        mem_ready = 1'b0;
        in_valid = 1'b1; opcode = ops[0]; rdst = 4'd0; rsrc = 4'd15; flag_type = 4'b0001;
        for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
            @(negedge clk);
            if (cyc == 3 || cyc == 12) begin
                check_cnt++; if (mem_we !== 1'b1) $display("FAIL bp_we_c%0d: got %b want 1", cyc, mem_we); else pass_cnt++;
                check_cnt++; if (mem_addr !== 4'h5 || mem_wdata !== ed[0]) $display("FAIL bp_hold_c%0d: got %h@%h want %h@5", cyc, mem_wdata, mem_addr, ed[0]); else pass_cnt++;
            end
            if (in_ready) idx++;
            else if (first_stall < 0) first_stall = idx;
            @(posedge clk); #1;
            if (cyc == 12) begin
                check_cnt++; if (log_addr.size() !== base) $display("FAIL bp_nowrite: got %0d writes want 0", log_addr.size() - base); else pass_cnt++;
                mem_ready = 1'b1;
            end
            if (idx < 8) begin
                opcode = ops[idx]; rdst = 4'(idx); rsrc = 4'(15 - idx);
            end else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check_cnt++; if (first_stall !== 5) $display("FAIL bp_accepts: got %0d want 5", first_stall); else pass_cnt++;
        check_cnt++; if (idx !== 8) $display("FAIL bp_stream: got %0d accepts want 8", idx); else pass_cnt++;
        cycles(12);
        check_cnt++;
        if (log_addr.size() !== base + 8) $display("FAIL bp_nwrites: got %0d want 8", log_addr.size() - base);
        else begin
            pass_cnt++;
            for (int i = 0; i < 8; i++) begin
                check_cnt++;
                if (log_addr[base+i] !== 4'(5 + i) || log_data[base+i] !== ed[i])
                    $display("FAIL bp_word%0d: got %h@%h want %h@%h", i, log_data[base+i], log_addr[base+i], ed[i], 4'(5 + i));
                else pass_cnt++;
            end
        end
        check_cnt++; if (word_count !== 5'd15) $display("FAIL bp_wc: got %0d want 15", word_count); else pass_cnt++;
    endtask

    task automatic test_flush(input bit use_reset);
        int we_base, lbase;
        mem_ready = 1'b0;
        send(8'h01, 4'd1, 4'd2, 8'h00, 4'b0001);
        send(8'h02, 4'd3, 4'd4, 8'h00, 4'b0001);
        send(8'h03, 4'd5, 4'd6, 8'h00, 4'b0001);
        cycles(2);
        if (use_reset) reset = 1'b1; else prog_start = 1'b1;
        mem_ready = 1'b1;
        in_valid = 1'b1; opcode = 8'h04; rdst = 4'd7; rsrc = 4'd8; flag_type = 4'b0001;
        we_base = we_seen;
        lbase = log_addr.size();
        @(negedge clk);
        check_cnt++; if (in_ready !== 1'b0) $display("FAIL flush%0d_in_ready: got %b want 0", use_reset, in_ready); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0; prog_start = 1'b0; in_valid = 1'b0;
        cycles(6);
        check_cnt++; if (we_seen !== we_base) $display("FAIL flush%0d_no_we: got %0d strobes want 0", use_reset, we_seen - we_base); else pass_cnt++;
        check_cnt++; if (log_addr.size() !== lbase) $display("FAIL flush%0d_no_write: got %0d writes want 0", use_reset, log_addr.size() - lbase); else pass_cnt++;
        check_cnt++; if (mem_addr !== 4'hE) $display("FAIL flush%0d_addr: got %h want e", use_reset, mem_addr); else pass_cnt++;
        check_cnt++; if (word_count !== 5'd0) $display("FAIL flush%0d_wc: got %0d want 0", use_reset, word_count); else pass_cnt++;
        send(8'h0C, 4'd9, 4'd10, 8'h00, 4'b0001);
        cycles(4);
        check_cnt++;
        if (log_addr.size() !== lbase + 1) $display("FAIL flush%0d_restart_n: got %0d want 1", use_reset, log_addr.size() - lbase);
        else if (log_addr[lbase] !== 4'hE || log_data[lbase] !== 16'h0C9A)
            $display("FAIL flush%0d_restart_word: got %h@%h want 0c9a@e", use_reset, log_data[lbase], log_addr[lbase]);
        else pass_cnt++;
        check_cnt++; if (word_count !== 5'd1) $display("FAIL flush%0d_restart_wc: got %0d want 1", use_reset, word_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_types_wrap();
        test_illegal();
        test_backpressure();
        test_flush(1'b1);
        test_flush(1'b0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
